// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM port state as reported by the RAM mux.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/diaosi_types_pkg.sv
// Memory-controller types: arbiter state encoding and transaction limits.
package diaosi_types_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Longest transaction the arbiter holds a grant for, in words.
  localparam int unsigned ARB_MAX_WORDS = 2;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection: first set request strictly after rr_ptr_i,
// wrapping modulo NREQ; rr_ptr_i itself has the lowest priority.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   rr_ptr_i,
  output logic [IW-1:0]   winner_o,
  output logic            valid_o
);

  logic [IW-1:0] idx;

  // Scan from farthest to nearest so the nearest set bit after rr_ptr_i wins.
  always_comb begin
    winner_o = '0;
    valid_o  = |req_i;
    idx      = '0;
    for (int unsigned i = NREQ; i >= 1; i--) begin
      idx = rr_ptr_i + IW'(i);
      if (req_i[idx]) winner_o = idx;
    end
  end

endmodule

// File: rtl/ram_arbiter_rr.sv
// Round-robin arbiter for the single RAM port shared by NREQ cache requesters
// (2k = dcache of CPU k, 2k+1 = icache of CPU k). Holds a one-hot grant for a
// 1- or 2-word transaction and aborts on withdrawal, RAM ERROR or timeout.
// Optional: define ARB_PERF_CNT_EN to add per-requester completion counters
// readable through perf_sel/perf_cnt.
module ram_arbiter_rr
  import cpu_types_pkg::*;
  import diaosi_types_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         req_burst,
  input  ramstate_t               ramstate,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_idx,
  output logic                    busy,
  output logic                    word_sel,
  output logic [NREQ-1:0]         word_ack,
  output logic                    xfer_done,
  output logic                    abort
`ifdef ARB_PERF_CNT_EN
  ,
  input  logic [$clog2(NREQ)-1:0] perf_sel,
  output logic [31:0]             perf_cnt
`endif
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(TIMEOUT);

  arb_state_t      state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   gnt_idx_q, gnt_idx_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            burst_q, burst_d;
  logic            word_sel_q, word_sel_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [IW-1:0]   winner;
  logic            winner_vld;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .winner_o (winner),
    .valid_o  (winner_vld)
  );

  // Next-state and pulse outputs; grant-side checks follow strict priority.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_idx_d  = gnt_idx_q;
    gnt_d      = gnt_q;
    burst_d    = burst_q;
    word_sel_d = word_sel_q;
    cnt_d      = cnt_q;
    word_ack   = '0;
    xfer_done  = 1'b0;
    abort      = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (winner_vld) begin
          state_d    = ARB_GRANT;
          gnt_idx_d  = winner;
          gnt_d      = '0;
          gnt_d[winner] = 1'b1;
          burst_d    = req_burst[winner];
          word_sel_d = 1'b0;
          cnt_d      = '0;
        end
      end
      ARB_GRANT: begin
        if (!req[gnt_idx_q] || ramstate == ERROR) begin
          abort = 1'b1;
        end else if (ramstate == ACCESS) begin
          word_ack = gnt_q;
          cnt_d    = '0;
          if (word_sel_q == burst_q) begin
            xfer_done = 1'b1;
          end else begin
            word_sel_d = 1'b1;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end

        // Any end of transaction releases the bus for one turnaround cycle.
        if (abort || xfer_done) begin
          state_d    = ARB_IDLE;
          rr_ptr_d   = gnt_idx_q;
          gnt_idx_d  = '0;
          gnt_d      = '0;
          word_sel_d = 1'b0;
          cnt_d      = '0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and grant registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= IW'(NREQ - 1);
      gnt_idx_q  <= '0;
      gnt_q      <= '0;
      burst_q    <= 1'b0;
      word_sel_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_idx_q  <= gnt_idx_d;
      gnt_q      <= gnt_d;
      burst_q    <= burst_d;
      word_sel_q <= word_sel_d;
      cnt_q      <= cnt_d;
    end
  end

  assign gnt      = gnt_q;
  assign gnt_idx  = gnt_idx_q;
  assign busy     = (state_q == ARB_GRANT);
  assign word_sel = word_sel_q;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_q [NREQ];
  logic [31:0] perf_cnt_q;

  // Saturating completion counters and registered read-out mux.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < NREQ; i++) perf_q[i] <= '0;
      perf_cnt_q <= '0;
    end else begin
      if (xfer_done && perf_q[gnt_idx_q] != '1)
        perf_q[gnt_idx_q] <= perf_q[gnt_idx_q] + 32'd1;
      perf_cnt_q <= perf_q[perf_sel];
    end
  end

  assign perf_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_ram_arbiter_rr.sv
// Directed self-checking bench for ram_arbiter_rr (NREQ=4, TIMEOUT=64).
// Inputs change 1 time unit after posedge; outputs are checked at negedge.
module tb_ram_arbiter_rr;
  import cpu_types_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] req_burst = '0;
  ramstate_t  ramstate = FREE;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       busy;
  logic       word_sel;
  logic [3:0] word_ack;
  logic       xfer_done;
  logic       abort;
`ifdef ARB_PERF_CNT_EN
  logic [1:0]  perf_sel = '0;
  logic [31:0] perf_cnt;
`endif

  int tests = 0;
  int fails = 0;

  ram_arbiter_rr #(.NREQ(4), .TIMEOUT(64)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req       (req),
    .req_burst (req_burst),
    .ramstate  (ramstate),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .busy      (busy),
    .word_sel  (word_sel),
    .word_ack  (word_ack),
    .xfer_done (xfer_done),
    .abort     (abort)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_sel  (perf_sel),
    .perf_cnt  (perf_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; req = '0; ramstate = FREE;
    tick(); tick();
    @(negedge CLK);
    tests++;
    if ({gnt, gnt_idx, busy, word_sel, word_ack, xfer_done, abort} !== 15'd0) begin
      fails++;
      $display("FAIL reset_outputs: got gnt=%b idx=%0d busy=%b ws=%b ack=%b done=%b abort=%b, want all 0",
               gnt, gnt_idx, busy, word_sel, word_ack, xfer_done, abort);
    end
    tick();
    RST = 1'b0;
  endtask

  // Burst on requester 0, ACCESS in grant cycles 3 and 5.
  task automatic test_single_burst();
    req = 4'b0001; req_burst = 4'b0001; ramstate = FREE;
    tick(); // cycle 1
    @(negedge CLK);
    tests++;
    if (gnt !== 4'b0001 || busy !== 1'b1 || word_sel !== 1'b0) begin
      fails++;
      $display("FAIL burst_grant: got gnt=%b busy=%b ws=%b, want 0001 1 0", gnt, busy, word_sel);
    end
    tick(); ramstate = BUSY;   // cycle 2
    tick(); ramstate = ACCESS; // cycle 3
    @(negedge CLK);
    tests++;
    if (word_ack !== 4'b0001 || xfer_done !== 1'b0) begin
      fails++;
      $display("FAIL burst_word0: got ack=%b done=%b, want 0001 0", word_ack, xfer_done);
    end
    tick(); ramstate = BUSY;   // cycle 4
    @(negedge CLK);
    tests++;
    if (word_sel !== 1'b1 || word_ack !== 4'b0000 || gnt !== 4'b0001) begin
      fails++;
      $display("FAIL burst_wait: got ws=%b ack=%b gnt=%b, want 1 0000 0001", word_sel, word_ack, gnt);
    end
    tick(); ramstate = ACCESS; // cycle 5
    @(negedge CLK);
    tests++;
    if (word_ack !== 4'b0001 || xfer_done !== 1'b1 || abort !== 1'b0) begin
      fails++;
      $display("FAIL burst_word1: got ack=%b done=%b abort=%b, want 0001 1 0", word_ack, xfer_done, abort);
    end
    tick(); req = '0; ramstate = FREE; // cycle 6
    @(negedge CLK);
    tests++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || word_sel !== 1'b0) begin
      fails++;
      $display("FAIL burst_release: got gnt=%b busy=%b ws=%b, want 0000 0 0", gnt, busy, word_sel);
    end
  endtask

  // All requesting, single words, ACCESS always: 0,1,2,3,0 with idle gaps.
  task automatic test_round_robin();
    logic [1:0] exp_idx [5];
    logic [3:0] exp_gnt;
    exp_idx[0] = 2'd0; exp_idx[1] = 2'd1; exp_idx[2] = 2'd2;
    exp_idx[3] = 2'd3; exp_idx[4] = 2'd0;
    RST = 1'b1; tick();
    RST = 1'b0; req = 4'b1111; req_burst = '0; ramstate = ACCESS;
    for (int k = 0; k < 5; k++) begin
      tick();
      @(negedge CLK);
      exp_gnt = 4'b0001 << exp_idx[k];
      tests++;
      if (gnt_idx !== exp_idx[k] || gnt !== exp_gnt || xfer_done !== 1'b1) begin
        fails++;
        $display("FAIL rr_grant%0d: got idx=%0d gnt=%b done=%b, want %0d %b 1",
                 k, gnt_idx, gnt, xfer_done, exp_idx[k], exp_gnt);
      end
      tick();
      @(negedge CLK);
      tests++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || word_ack !== 4'b0000) begin
        fails++;
        $display("FAIL rr_gap%0d: got gnt=%b busy=%b ack=%b, want 0000 0 0000", k, gnt, busy, word_ack);
      end
    end
    req = '0; ramstate = FREE;
  endtask

  // Withdrawal beats same-cycle ACCESS; next search starts after index 2.
  task automatic test_withdraw();
    req = 4'b0100; ramstate = FREE;
    tick();
    @(negedge CLK);
    tests++;
    if (gnt_idx !== 2'd2 || gnt !== 4'b0100) begin
      fails++;
      $display("FAIL wd_grant: got idx=%0d gnt=%b, want 2 0100", gnt_idx, gnt);
    end
    tick(); req = 4'b0000; ramstate = ACCESS;
    @(negedge CLK);
    tests++;
    if (abort !== 1'b1 || word_ack !== 4'b0000 || xfer_done !== 1'b0) begin
      fails++;
      $display("FAIL wd_abort: got abort=%b ack=%b done=%b, want 1 0000 0", abort, word_ack, xfer_done);
    end
    tick(); req = 4'b1011; ramstate = FREE;
    @(negedge CLK);
    tests++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      fails++;
      $display("FAIL wd_gap: got gnt=%b busy=%b, want 0000 0", gnt, busy);
    end
    tick();
    @(negedge CLK);
    tests++;
    if (gnt_idx !== 2'd3 || gnt !== 4'b1000) begin
      fails++;
      $display("FAIL wd_next: got idx=%0d gnt=%b, want 3 1000", gnt_idx, gnt);
    end
    tick(); req = '0;
    tick();
  endtask

  // BUSY for 64 grant cycles -> abort on the 64th; then ERROR aborts at once.
  task automatic test_timeout_error();
    req = 4'b0001; ramstate = BUSY;
    for (int n = 1; n <= 64; n++) begin
      tick();
      @(negedge CLK);
      tests++;
      if (abort !== (n == 64) || busy !== 1'b1) begin
        fails++;
        $display("FAIL timeout_c%0d: got abort=%b busy=%b, want %b 1", n, abort, busy, (n == 64));
      end
    end
    tick();
    @(negedge CLK);
    tests++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      fails++;
      $display("FAIL timeout_release: got gnt=%b busy=%b, want 0000 0", gnt, busy);
    end
    tick(); ramstate = BUSY;
    @(negedge CLK);
    tests++;
    if (gnt !== 4'b0001 || abort !== 1'b0) begin
      fails++;
      $display("FAIL err_grant: got gnt=%b abort=%b, want 0001 0", gnt, abort);
    end
    tick(); ramstate = ERROR;
    @(negedge CLK);
    tests++;
    if (abort !== 1'b1 || word_ack !== 4'b0000 || xfer_done !== 1'b0) begin
      fails++;
      $display("FAIL err_abort: got abort=%b ack=%b done=%b, want 1 0000 0", abort, word_ack, xfer_done);
    end
    tick(); req = '0; ramstate = FREE;
    tick();
  endtask

  // Reset while on word 1 of a burst drops everything silently.
  task automatic test_reset_mid();
    req = 4'b1111; req_burst = 4'b1111; ramstate = FREE;
    tick();
    tick(); ramstate = ACCESS;
    tick(); ramstate = BUSY;
    @(negedge CLK);
    tests++;
    if (word_sel !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_pre: got ws=%b busy=%b, want 1 1", word_sel, busy);
    end
    RST = 1'b1;
    tick();
    @(negedge CLK);
    tests++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || word_sel !== 1'b0 || xfer_done !== 1'b0 || abort !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_drop: got gnt=%b busy=%b ws=%b done=%b abort=%b, want 0000 0 0 0 0",
               gnt, busy, word_sel, xfer_done, abort);
    end
    RST = 1'b0;
    tick();
    @(negedge CLK);
    tests++;
    if (gnt_idx !== 2'd0 || gnt !== 4'b0001) begin
      fails++;
      $display("FAIL rstmid_next: got idx=%0d gnt=%b, want 0 0001", gnt_idx, gnt);
    end
    req = '0; req_burst = '0;
    RST = 1'b1; tick(); RST = 1'b0;
  endtask

`ifdef ARB_PERF_CNT_EN
  task automatic test_perf();
    RST = 1'b1; tick(); RST = 1'b0;
    for (int t = 0; t < 3; t++) begin
      req = 4'b0010; req_burst = '0; ramstate = FREE;
      tick(); ramstate = ACCESS;
      tick(); req = '0; ramstate = FREE;
    end
    perf_sel = 2'd1;
    tick(); tick();
    @(negedge CLK);
    tests++;
    if (perf_cnt !== 32'd3) begin
      fails++;
      $display("FAIL perf_count: got %0d, want 3", perf_cnt);
    end
    dut.perf_q[1] = 32'hFFFF_FFFF;
    req = 4'b0010; ramstate = FREE;
    tick(); ramstate = ACCESS;
    tick(); req = '0; ramstate = FREE;
    tick(); tick();
    @(negedge CLK);
    tests++;
    if (perf_cnt !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL perf_sat: got %h, want ffffffff", perf_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_withdraw();
    test_timeout_error();
    test_reset_mid();
`ifdef ARB_PERF_CNT_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
